// File: rtl/avg_filter_pkg.sv
// rtl/avg_filter_pkg.sv - shared state encoding and default widths for the averaging stage
package avg_filter_pkg;

    // Defaults shared with control_fsm and the compare stage
    localparam int AVG_DATA_W    = 12;
    localparam int AVG_TAPS_LOG2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } avg_state_t;

    // A single-tap build still needs a 1-bit counter to stay a legal vector
    function automatic int cnt_width(input int taps_log2);
        return (taps_log2 > 0) ? taps_log2 : 1;
    endfunction

endpackage

// File: rtl/avg_filter.sv
// rtl/avg_filter.sv - block-averaging filter: collects 2**TAPS_LOG2 samples, outputs rounded mean
module avg_filter
    import avg_filter_pkg::*;
#(
    parameter int DATA_W    = AVG_DATA_W,
    parameter int TAPS_LOG2 = AVG_TAPS_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              filter_enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W-1:0] filter_out,
    output logic              filter_done,
    output logic              busy
);

    localparam int N     = 1 << TAPS_LOG2;
    localparam int SUM_W = DATA_W + TAPS_LOG2;
    localparam int CNT_W = cnt_width(TAPS_LOG2);

    // Half an LSB of the result; zero when a single sample passes straight through
    localparam logic [SUM_W-1:0] ROUND    = SUM_W'(N >> 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    avg_state_t        state;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic [SUM_W-1:0]  sum_rounded;

    assign accept = sample_valid & sample_ready;

    // The full-scale sum plus the rounding constant still fits SUM_W bits, so no carry is lost
    assign sum_rounded = sum + ROUND;

    // Sequencer, accumulator and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sum        <= '0;
            cnt        <= '0;
            filter_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (filter_enable) begin
                        state <= ST_FILL;
                        sum   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_FILL: begin
                    // Dropping enable abandons the window even if a sample lands this cycle
                    if (!filter_enable) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        sum <= sum + SUM_W'(sample_in);
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    filter_out <= DATA_W'(sum_rounded >> TAPS_LOG2);
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status are pure decodes of the registered state
    assign sample_ready = (state == ST_FILL);
    assign filter_done  = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_avg_filter.sv
// tb/tb_avg_filter.sv - randomized self-checking bench for avg_filter (N=4 and N=1 builds)
module tb_avg_filter;

    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          en   [2];
    logic          vld  [2];
    logic [DW-1:0] smp  [2];
    logic          rdy  [2];
    logic [DW-1:0] fout [2];
    logic          done [2];
    logic          busy [2];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: window progress kept as plain sum/count, result by integer division
    int m_sum [2];
    int m_cnt [2];
    int m_out [2];
    bit m_coll[2];
    bit m_wait[2];
    bit m_done[2];

    avg_filter #(.DATA_W(DW), .TAPS_LOG2(2)) dut_n4 (
        .clk(clk), .reset(reset), .filter_enable(en[0]), .sample_in(smp[0]),
        .sample_valid(vld[0]), .sample_ready(rdy[0]), .filter_out(fout[0]),
        .filter_done(done[0]), .busy(busy[0])
    );

    avg_filter #(.DATA_W(DW), .TAPS_LOG2(0)) dut_n1 (
        .clk(clk), .reset(reset), .filter_enable(en[1]), .sample_in(smp[1]),
        .sample_valid(vld[1]), .sample_ready(rdy[1]), .filter_out(fout[1]),
        .filter_done(done[1]), .busy(busy[1])
    );

    function automatic int taps(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_out[i] = 0;
            m_coll[i] = 0; m_wait[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int n;
        n = taps(i);
        if (m_done[i]) begin
            m_done[i] = 0;
        end else if (m_wait[i]) begin
            m_wait[i] = 0;
            m_out[i]  = (m_sum[i] + n / 2) / n;
            m_done[i] = 1;
        end else if (m_coll[i]) begin
            if (!en[i]) begin
                m_coll[i] = 0;
            end else if (vld[i]) begin
                m_sum[i] += int'(smp[i]);
                m_cnt[i] += 1;
                if (m_cnt[i] == n) begin
                    m_coll[i] = 0;
                    m_wait[i] = 1;
                end
            end
        end else if (en[i]) begin
            m_coll[i] = 1;
            m_sum[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // Advance one clock with current inputs; return 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; vld[i] = 1'b0; smp[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            compared += 4;
            if (rdy[i] !== 1'b0) begin mismatched++; $display("FAIL reset_ready dut=%0d got=%b exp=0", i, rdy[i]); end
            if (done[i] !== 1'b0) begin mismatched++; $display("FAIL reset_done dut=%0d got=%b exp=0", i, done[i]); end
            if (busy[i] !== 1'b0) begin mismatched++; $display("FAIL reset_busy dut=%0d got=%b exp=0", i, busy[i]); end
            if (fout[i] !== '0) begin mismatched++; $display("FAIL reset_out dut=%0d got=%0d exp=0", i, fout[i]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int vals[4] = '{10, 20, 30, 41};
        en[0] = 1'b1; vld[0] = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            smp[0] = DW'(vals[k]); vld[0] = 1'b1;
            tick();
            compared++;
            if (rdy[0] !== m_coll[0] || done[0] !== m_done[0]) begin
                mismatched++;
                $display("FAIL basic_fill k=%0d got rdy=%b done=%b exp rdy=%b done=%b", k, rdy[0], done[0], m_coll[0], m_done[0]);
            end
        end
        // Now in the calculation cycle; enable is ignored here
        vld[0] = 1'b0; en[0] = 1'b0;
        compared++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_calc got done=%b busy=%b rdy=%b exp 0 1 0", done[0], busy[0], rdy[0]);
        end
        tick();
        compared++;
        if (done[0] !== 1'b1 || fout[0] !== DW'(25)) begin
            mismatched++;
            $display("FAIL basic_result got done=%b out=%0d exp done=1 out=25", done[0], fout[0]);
        end
        tick();
        compared++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0 || fout[0] !== DW'(25)) begin
            mismatched++;
            $display("FAIL basic_after got done=%b busy=%b out=%0d exp 0 0 25", done[0], busy[0], fout[0]);
        end
    endtask

    task automatic test_extremes();
        int v[2] = '{4095, 0};
        for (int j = 0; j < 2; j++) begin
            en[0] = 1'b1; vld[0] = 1'b0;
            tick();
            for (int k = 0; k < 4; k++) begin
                smp[0] = DW'(v[j]); vld[0] = 1'b1;
                tick();
            end
            vld[0] = 1'b0; en[0] = 1'b0;
            tick();
            compared++;
            if (done[0] !== 1'b1 || fout[0] !== DW'(v[j]) || fout[0] !== DW'(m_out[0])) begin
                mismatched++;
                $display("FAIL extreme_result got done=%b out=%0d exp done=1 out=%0d", done[0], fout[0], v[j]);
            end
            tick();
        end
    endtask

    task automatic test_gaps();
        en[0] = 1'b1; vld[0] = 1'b0;
        tick();
        for (int c = 0; c < 7; c++) begin
            vld[0] = (c % 2 == 0);
            smp[0] = (c % 2 == 0) ? DW'(7) : DW'($urandom_range(0, 4095));
            tick();
            compared++;
            if (rdy[0] !== m_coll[0] || busy[0] !== 1'b1) begin
                mismatched++;
                $display("FAIL gaps_ready c=%0d got rdy=%b busy=%b exp rdy=%b busy=1", c, rdy[0], busy[0], m_coll[0]);
            end
        end
        vld[0] = 1'b1; en[0] = 1'b0;
        compared++;
        if (rdy[0] !== 1'b0) begin mismatched++; $display("FAIL gaps_calc_ready got=%b exp=0", rdy[0]); end
        tick();
        compared++;
        if (rdy[0] !== 1'b0 || done[0] !== 1'b1 || fout[0] !== DW'(7)) begin
            mismatched++;
            $display("FAIL gaps_done got rdy=%b done=%b out=%0d exp 0 1 7", rdy[0], done[0], fout[0]);
        end
        tick();
        compared++;
        if (rdy[0] !== 1'b0) begin mismatched++; $display("FAIL gaps_idle_ready got=%b exp=0", rdy[0]); end
        vld[0] = 1'b0;
    endtask

    task automatic test_abort();
        int prev;
        prev = m_out[0];
        en[0] = 1'b1; vld[0] = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            smp[0] = DW'($urandom_range(1000, 4000)); vld[0] = 1'b1;
            tick();
        end
        // Enable drops in the same cycle a sample is offered
        en[0] = 1'b0; smp[0] = DW'(999);
        tick();
        compared++;
        if (busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_idle got busy=%b rdy=%b exp 0 0", busy[0], rdy[0]);
        end
        vld[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (done[0] !== 1'b0 || fout[0] !== DW'(prev)) begin
                mismatched++;
                $display("FAIL abort_no_done k=%0d got done=%b out=%0d exp 0 %0d", k, done[0], fout[0], prev);
            end
        end
        en[0] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            smp[0] = DW'(100); vld[0] = 1'b1;
            tick();
        end
        vld[0] = 1'b0; en[0] = 1'b0;
        tick();
        compared++;
        if (done[0] !== 1'b1 || fout[0] !== DW'(100)) begin
            mismatched++;
            $display("FAIL abort_rerun got done=%b out=%0d exp 1 100", done[0], fout[0]);
        end
        tick();
    endtask

    task automatic test_random();
        int pulses = 0;
        for (int c = 0; c < 160; c++) begin
            en[0]  = ($urandom_range(0, 19) != 0);
            vld[0] = ($urandom_range(0, 3) != 0);
            smp[0] = DW'($urandom_range(0, 4095));
            tick();
            if (done[0] === 1'b1) pulses++;
            compared++;
            if (rdy[0] !== m_coll[0] || done[0] !== m_done[0] || busy[0] !== (m_coll[0] | m_wait[0] | m_done[0])
                || fout[0] !== DW'(m_out[0])) begin
                mismatched++;
                $display("FAIL random c=%0d got rdy=%b done=%b busy=%b out=%0d exp rdy=%b done=%b busy=%b out=%0d",
                         c, rdy[0], done[0], busy[0], fout[0], m_coll[0], m_done[0],
                         m_coll[0] | m_wait[0] | m_done[0], m_out[0]);
            end
        end
        compared++;
        if (pulses < 3) begin mismatched++; $display("FAIL random_pulses got=%0d exp>=3", pulses); end
        en[0] = 1'b0; vld[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int idx[$];
        logic [DW-1:0] held;
        held = fout[0];
        en[0] = 1'b1; vld[0] = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            smp[0] = DW'($urandom_range(0, 4095));
            tick();
            if (done[0] === 1'b1) begin
                idx.push_back(c);
                held = fout[0];
            end
            compared++;
            if (done[0] !== m_done[0] || fout[0] !== DW'(m_out[0]) || fout[0] !== held) begin
                mismatched++;
                $display("FAIL b2b c=%0d got done=%b out=%0d exp done=%b out=%0d held=%0d",
                         c, done[0], fout[0], m_done[0], m_out[0], held);
            end
        end
        compared++;
        if (idx.size() != 3) begin
            mismatched++;
            $display("FAIL b2b_count got=%0d exp=3", idx.size());
        end else begin
            compared++;
            if (idx[0] != 6 || idx[1] - idx[0] != 7 || idx[2] - idx[1] != 7) begin
                mismatched++;
                $display("FAIL b2b_period got=%0d,%0d,%0d exp=6,13,20", idx[0], idx[1], idx[2]);
            end
        end
        en[0] = 1'b0; vld[0] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        en[0] = 1'b1; vld[0] = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            smp[0] = DW'(7); vld[0] = 1'b1;
            tick();
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (rdy[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || fout[0] !== '0) begin
            mismatched++;
            $display("FAIL areset_fill got rdy=%b busy=%b done=%b out=%0d exp 0 0 0 0", rdy[0], busy[0], done[0], fout[0]);
        end
        reset = 1'b0; vld[0] = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            smp[0] = DW'(100); vld[0] = 1'b1;
            tick();
        end
        vld[0] = 1'b0; en[0] = 1'b0;
        compared++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_precalc got busy=%b done=%b exp 1 0", busy[0], done[0]);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (rdy[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || fout[0] !== '0) begin
            mismatched++;
            $display("FAIL areset_calc got rdy=%b busy=%b done=%b out=%0d exp 0 0 0 0", rdy[0], busy[0], done[0], fout[0]);
        end
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            compared++;
            if (done[0] !== 1'b0 || fout[0] !== '0) begin
                mismatched++;
                $display("FAIL areset_no_done k=%0d got done=%b out=%0d exp 0 0", k, done[0], fout[0]);
            end
        end
    endtask

    task automatic test_taps0();
        int pulses = 0;
        logic [DW-1:0] last_acc;
        last_acc = '0;
        en[1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            vld[1] = ($urandom_range(0, 2) != 0);
            smp[1] = DW'($urandom_range(0, 4095));
            if (m_coll[1] && vld[1]) last_acc = smp[1];
            tick();
            compared++;
            if (rdy[1] !== m_coll[1] || done[1] !== m_done[1] || busy[1] !== (m_coll[1] | m_wait[1] | m_done[1])
                || fout[1] !== DW'(m_out[1])) begin
                mismatched++;
                $display("FAIL taps0 c=%0d got rdy=%b done=%b busy=%b out=%0d exp rdy=%b done=%b out=%0d",
                         c, rdy[1], done[1], busy[1], fout[1], m_coll[1], m_done[1], m_out[1]);
            end
            if (done[1] === 1'b1) begin
                pulses++;
                compared++;
                if (fout[1] !== last_acc) begin
                    mismatched++;
                    $display("FAIL taps0_passthru c=%0d got=%0d exp=%0d", c, fout[1], last_acc);
                end
            end
        end
        compared++;
        if (pulses < 5) begin mismatched++; $display("FAIL taps0_pulses got=%0d exp>=5", pulses); end
        en[1] = 1'b0; vld[1] = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_gaps();
        test_abort();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_taps0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
